// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared widths, request type and arbiter state encoding for the writeback arbiter
//
// Contents:
//   WB_RWIDTH  - default register-address width (64 registers)
//   WB_DWIDTH  - default write-data width
//   wb_req_t   - one writeback request (addr, data) at default widths
//   wb_state_t - arbiter priority state {ALU_PRI, LSU_PRI}
package wb_pkg;

    localparam int WB_RWIDTH = 6;
    localparam int WB_DWIDTH = 32;

    typedef struct packed {
        logic [WB_RWIDTH-1:0] addr;
        logic [WB_DWIDTH-1:0] data;
    } wb_req_t;

    typedef enum logic {
        ALU_PRI = 1'b0,
        LSU_PRI = 1'b1
    } wb_state_t;

endpackage

// File: rtl/wb_fifo2.sv
// rtl/wb_fifo2.sv - two-entry in-order FIFO buffering load writeback requests
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset (empties the FIFO)
//   push        - enqueue push_data (ignored when full)
//   push_data   - entry to enqueue
//   pop         - dequeue the head (ignored when empty)
//   head_data   - current head entry (valid when count != 0)
//   count       - registered occupancy, 0..2
module wb_fifo2 #(
    parameter int W = 38
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head_data,
    output logic [1:0]   count
);

    logic [W-1:0] slot0_q, slot0_d;
    logic [W-1:0] slot1_q, slot1_d;
    logic         rd_ptr_q, rd_ptr_d;
    logic         wr_ptr_q, wr_ptr_d;
    logic [1:0]   count_q, count_d;
    logic         do_push;
    logic         do_pop;

    always_comb begin
        do_pop   = pop && (count_q != 2'd0);
        do_push  = push && (count_q != 2'd2);
        slot0_d  = slot0_q;
        slot1_d  = slot1_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;

        if (do_push) begin
            if (wr_ptr_q) begin
                slot1_d = push_data;
            end else begin
                slot0_d = push_data;
            end
            wr_ptr_d = ~wr_ptr_q;
        end

        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end

        // Push and pop together leave occupancy unchanged; the pointers
        // still advance independently so ordering is preserved.
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot0_q  <= '0;
            slot1_q  <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            slot0_q  <= slot0_d;
            slot1_q  <= slot1_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_data = rd_ptr_q ? slot1_q : slot0_q;
    assign count     = count_q;

endmodule

// File: rtl/writeback_arb.sv
// rtl/writeback_arb.sv - register-file writeback arbiter between an unbuffered ALU port and a buffered load port
//
// Ports:
//   clk, rst_n                     - clock, asynchronous active-low reset
//   alu_valid/alu_ready/alu_addr/alu_data - ALU result handshake (unbuffered)
//   lsu_valid/lsu_ready/lsu_addr/lsu_data - load result handshake (into 2-entry FIFO)
//   wa, wd, we                     - registered register-file write port
//   lsu_pend                       - load FIFO occupancy, 0..2
//
// Build option WB_ZERO_REG_EN: writes addressed to register 0 complete their
// handshake but never raise we.
module writeback_arb
    import wb_pkg::*;
#(
    parameter int RWIDTH     = WB_RWIDTH,
    parameter int DWIDTH     = WB_DWIDTH,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [RWIDTH-1:0] alu_addr,
    input  logic [DWIDTH-1:0] alu_data,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic [RWIDTH-1:0] lsu_addr,
    input  logic [DWIDTH-1:0] lsu_data,
    output logic [RWIDTH-1:0] wa,
    output logic [DWIDTH-1:0] wd,
    output logic              we,
    output logic [1:0]        lsu_pend
);

    localparam int FW = RWIDTH + DWIDTH;

    wb_state_t         state_q, state_d;
    logic [3:0]        stall_q, stall_d;
    logic [RWIDTH-1:0] wa_q, wa_d;
    logic [DWIDTH-1:0] wd_q, wd_d;
    logic              we_q, we_d;

    logic [FW-1:0]     head_data;
    logic [1:0]        fifo_cnt;
    logic              fifo_empty;
    logic              lsu_push;
    logic              fifo_pop;
    logic              alu_hs;
    logic              sel_valid;
    logic [RWIDTH-1:0] sel_addr;
    logic [DWIDTH-1:0] sel_data;

    // Readiness depends only on registered state so neither ready path
    // combinationally loops through the same-cycle selection.
    assign alu_ready  = (state_q == ALU_PRI);
    assign lsu_ready  = (fifo_cnt != 2'd2);
    assign alu_hs     = alu_valid && alu_ready;
    assign lsu_push   = lsu_valid && lsu_ready;
    assign fifo_empty = (fifo_cnt == 2'd0);

    wb_fifo2 #(
        .W(FW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (lsu_push),
        .push_data ({lsu_addr, lsu_data}),
        .pop       (fifo_pop),
        .head_data (head_data),
        .count     (fifo_cnt)
    );

    always_comb begin
        state_d   = state_q;
        stall_d   = stall_q;
        fifo_pop  = 1'b0;
        sel_valid = 1'b0;
        sel_addr  = alu_addr;
        sel_data  = alu_data;

        case (state_q)
            ALU_PRI: begin
                if (alu_hs) begin
                    sel_valid = 1'b1;
                end else if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    sel_valid = 1'b1;
                    sel_addr  = head_data[FW-1:DWIDTH];
                    sel_data  = head_data[DWIDTH-1:0];
                end
            end
            LSU_PRI: begin
                state_d = ALU_PRI;
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    sel_valid = 1'b1;
                    sel_addr  = head_data[FW-1:DWIDTH];
                    sel_data  = head_data[DWIDTH-1:0];
                end
            end
            default: state_d = ALU_PRI;
        endcase

        if (fifo_pop) begin
            stall_d = 4'd0;
        end else if (!fifo_empty) begin
            stall_d = stall_q + 4'd1;
        end

        // A starved load forces one ALU-blocked cycle; skip the switch if the
        // head is draining anyway this cycle.
        if (stall_q == 4'(STARVE_MAX)) begin
            stall_d = 4'd0;
            if (!fifo_pop) begin
                state_d = LSU_PRI;
            end
        end

        we_d = sel_valid;
`ifdef WB_ZERO_REG_EN
        if (sel_addr == '0) begin
            we_d = 1'b0;
        end
`endif
        wa_d = we_d ? sel_addr : wa_q;
        wd_d = we_d ? sel_data : wd_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ALU_PRI;
            stall_q <= 4'd0;
            wa_q    <= '0;
            wd_q    <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
            we_q    <= we_d;
        end
    end

    assign wa       = wa_q;
    assign wd       = wd_q;
    assign we       = we_q;
    assign lsu_pend = fifo_cnt;

endmodule
